// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: requester ownership, in-flight read tags
// and arbitration states. The width macros mirror common_params.h.
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef DATA_W
`define DATA_W 64
`endif

package mem_port_arbiter_pkg;

   localparam int ADDR_W = `ADDR_W;
   localparam int DATA_W = `DATA_W;
   localparam int BE_W   = 8;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_t;

   typedef struct packed {
      logic   valid;
      owner_t owner;
   } mem_tag_t;

   typedef enum logic {
      ARB_D_PRI  = 1'b0,
      ARB_IF_PRI = 1'b1
   } arb_state_t;

   localparam mem_tag_t TAG_IDLE = '{valid: 1'b0, owner: OWN_D};

   // A flushed fetch response must never surface; data responses pass untouched.
   function automatic mem_tag_t kill_if_tag(input mem_tag_t tag, input logic kill_if);
      mem_tag_t res;
      res = tag;
      if (kill_if && tag.owner == OWN_IF) res.valid = 1'b0;
      return res;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_tag_pipe.sv
// Shift register of read tags that lines each granted read up with the cycle its
// memory data returns; the head entry steers mem_rdata to its requester.
module mem_tag_pipe
   import mem_port_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic     clk,
   input  logic     rstn,
   input  mem_tag_t push,
   input  logic     kill_if,
   output mem_tag_t head
);

   mem_tag_t [DEPTH-1:0] stage;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         // NOTE: the tag stages must be reset, unlike a data RAM, because a stale
         // valid bit would produce a phantom rvalid after reset is released.
         stage <= {DEPTH{TAG_IDLE}};
      end else begin
         stage[0] <= kill_if_tag(push, kill_if);
         for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= kill_if_tag(stage[i-1], kill_if);
         end
      end
   end

   assign head = stage[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Single memory port shared by fetch and load/store, with data priority, fetch
// starvation protection, registered memory command and flush-kill of fetch reads.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int LOAD_LATENCY = 1,
   parameter int STARVE_MAX   = 4
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              flush,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [BE_W-1:0]   d_we,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [BE_W-1:0]   mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   arb_state_t       state;
   logic [CNT_W-1:0] starve_cnt;
   logic             if_win;
   logic             d_win;
   mem_tag_t         push_tag;
   mem_tag_t         head_tag;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      if_win = 1'b0;
      d_win  = 1'b0;
      unique case (state)
         ARB_IF_PRI: begin
            if_win = if_req && !flush;
            d_win  = d_req && !if_win;
         end
         default: begin
            d_win  = d_req;
            if_win = if_req && !d_req && !flush;
         end
      endcase
   end

   // Reset only gates the visible grants; internal winners feed registers that are
   // themselves held in reset.
   assign if_gnt = if_win && rstn;
   assign d_gnt  = d_win && rstn;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= ARB_D_PRI;
         starve_cnt <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register
         // samples the pre-edge values regardless of statement order.
         if (if_win || !if_req) begin
            starve_cnt <= '0;
         end else if (state == ARB_D_PRI && d_win) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
         end
         unique case (state)
            ARB_D_PRI: begin
               if (if_req && d_win && (starve_cnt + CNT_W'(1)) >= STARVE_LIM) state <= ARB_IF_PRI;
            end
            ARB_IF_PRI: begin
               if (if_win) state <= ARB_D_PRI;
            end
            default: state <= ARB_D_PRI;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mem_addr  <= '0;
         mem_we    <= '0;
         mem_wdata <= '0;
      end else if (d_win) begin
         mem_addr  <= d_addr;
         mem_we    <= d_we;
         mem_wdata <= d_wdata;
      end else if (if_win) begin
         mem_addr  <= if_addr;
         mem_we    <= '0;
      end else begin
         mem_we    <= '0;
      end
   end

   always_comb begin
      push_tag.valid = if_win || (d_win && d_we == '0);
      push_tag.owner = if_win ? OWN_IF : OWN_D;
   end

   // One extra stage covers the command register between grant and memory.
   mem_tag_pipe #(
      .DEPTH(LOAD_LATENCY + 1)
   ) u_tag_pipe (
      .clk    (clk),
      .rstn   (rstn),
      .push   (push_tag),
      .kill_if(flush),
      .head   (head_tag)
   );

   assign if_rvalid = head_tag.valid && head_tag.owner == OWN_IF;
   assign d_rvalid  = head_tag.valid && head_tag.owner == OWN_D;
   assign if_rdata  = if_rvalid ? mem_rdata : '0;
   assign d_rdata   = d_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a write-first, one-cycle-latency memory model.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   logic              clk = 1'b0;
   logic              rstn;
   logic              flush;
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;
   logic              d_req;
   logic [ADDR_W-1:0] d_addr;
   logic [BE_W-1:0]   d_we;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic [BE_W-1:0]   mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   int checks   = 0;
   int failures = 0;

   mem_port_arbiter #(
      .LOAD_LATENCY(1),
      .STARVE_MAX  (4)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .flush    (flush),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_gnt   (if_gnt),
      .if_rvalid(if_rvalid),
      .if_rdata (if_rdata),
      .d_req    (d_req),
      .d_addr   (d_addr),
      .d_we     (d_we),
      .d_wdata  (d_wdata),
      .d_gnt    (d_gnt),
      .d_rvalid (d_rvalid),
      .d_rdata  (d_rdata),
      .mem_addr (mem_addr),
      .mem_we   (mem_we),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Memory model: byte-enabled write-first array, registered read data.
   logic [DATA_W-1:0] tb_mem [256];
   logic [DATA_W-1:0] rd_q;
   logic [DATA_W-1:0] wr_word;

   always_comb begin
      wr_word = tb_mem[mem_addr[7:0]];
      for (int b = 0; b < BE_W; b++) begin
         if (mem_we[b]) wr_word[b*8 +: 8] = mem_wdata[b*8 +: 8];
      end
   end

   always @(posedge clk) begin
      if (mem_we != '0) tb_mem[mem_addr[7:0]] <= wr_word;
      rd_q <= wr_word;
   end

   assign mem_rdata = rd_q;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush  = 1'b0;
      if_req = 1'b0;
      d_req  = 1'b0;
      d_we   = '0;
   endtask

   typedef struct {
      logic            if_req;
      logic            d_req;
      logic [BE_W-1:0] d_we;
      logic            flush;
      logic            exp_if_gnt;
      logic            exp_d_gnt;
      logic [BE_W-1:0] exp_mem_we;
   } vec_t;

   vec_t vecs [8];

   initial begin
      vecs[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[1] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
      vecs[2] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00};
      vecs[3] = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF};
      vecs[4] = '{1'b1, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b1, 8'h0F};
      vecs[5] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
      vecs[6] = '{1'b1, 1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 8'h03};
      vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};

      for (int i = 0; i < 256; i++) tb_mem[i] = {32'hC0DE_0000, 32'(i)};
      tb_mem[8'h10] = 64'hAAAA_0000_0000_0010;

      // Reset state, with requests pending to prove grants are held low.
      rstn    = 1'b0;
      idle();
      if_addr = 32'h10;
      d_addr  = 32'h40;
      d_wdata = 64'h5555;
      if_req  = 1'b1;
      d_req   = 1'b1;
      #2;
      check("rst_if_gnt", 64'(if_gnt), 64'h0);
      check("rst_d_gnt", 64'(d_gnt), 64'h0);
      check("rst_mem_we", 64'(mem_we), 64'h0);
      check("rst_mem_addr", 64'(mem_addr), 64'h0);
      check("rst_rvalid", 64'({if_rvalid, d_rvalid}), 64'h0);
      idle();
      tick();
      tick();
      rstn = 1'b1;
      tick();

      // Single-cycle grant table, each vector followed by an idle cycle.
      for (int i = 0; i < 8; i++) begin
         if_req = vecs[i].if_req;
         d_req  = vecs[i].d_req;
         d_we   = vecs[i].d_we;
         flush  = vecs[i].flush;
         #1;
         check($sformatf("vec%0d_if_gnt", i), 64'(if_gnt), 64'(vecs[i].exp_if_gnt));
         check($sformatf("vec%0d_d_gnt", i), 64'(d_gnt), 64'(vecs[i].exp_d_gnt));
         tick();
         idle();
         check($sformatf("vec%0d_mem_we", i), 64'(mem_we), 64'(vecs[i].exp_mem_we));
         tick();
      end
      tick();

      // Fetch only.
      if_req  = 1'b1;
      if_addr = 32'h10;
      #1;
      check("fetch_if_gnt", 64'(if_gnt), 64'h1);
      tick();
      idle();
      check("fetch_mem_addr", 64'(mem_addr), 64'h10);
      check("fetch_mem_we", 64'(mem_we), 64'h0);
      check("fetch_early_rvalid", 64'(if_rvalid), 64'h0);
      tick();
      check("fetch_if_rvalid", 64'(if_rvalid), 64'h1);
      check("fetch_if_rdata", if_rdata, 64'hAAAA_0000_0000_0010);
      check("fetch_d_rvalid", 64'(d_rvalid), 64'h0);
      tick();

      // Collision with a store: data wins, no response returns.
      if_req  = 1'b1;
      d_req   = 1'b1;
      d_we    = 8'hFF;
      d_addr  = 32'h20;
      d_wdata = 64'h1234;
      #1;
      check("coll_d_gnt", 64'(d_gnt), 64'h1);
      check("coll_if_gnt", 64'(if_gnt), 64'h0);
      tick();
      idle();
      check("coll_mem_we", 64'(mem_we), 64'hFF);
      check("coll_mem_wdata", mem_wdata, 64'h1234);
      check("coll_mem_addr", 64'(mem_addr), 64'h20);
      for (int c = 0; c < 3; c++) begin
         check($sformatf("coll_no_rvalid%0d", c), 64'({if_rvalid, d_rvalid}), 64'h0);
         tick();
      end

      // Starvation: data wins four times, fetch is forced, then data again.
      if_req = 1'b1;
      d_req  = 1'b1;
      d_we   = 8'h00;
      d_addr = 32'h40;
      for (int c = 0; c < 6; c++) begin
         #1;
         check($sformatf("starve%0d_if_gnt", c), 64'(if_gnt), 64'(c == 4));
         check($sformatf("starve%0d_d_gnt", c), 64'(d_gnt), 64'(c != 4));
         tick();
      end
      idle();
      tick();
      tick();
      tick();

      // Flush kill: fetch at t, flush plus a load at t+1.
      if_req  = 1'b1;
      if_addr = 32'h10;
      #1;
      check("flush_if_gnt_t", 64'(if_gnt), 64'h1);
      tick();
      flush  = 1'b1;
      if_req = 1'b1;
      d_req  = 1'b1;
      d_we   = 8'h00;
      d_addr = 32'h20;
      #1;
      check("flush_if_gnt_t1", 64'(if_gnt), 64'h0);
      check("flush_d_gnt_t1", 64'(d_gnt), 64'h1);
      tick();
      idle();
      check("flush_no_if_rvalid", 64'(if_rvalid), 64'h0);
      check("flush_no_d_rvalid_t2", 64'(d_rvalid), 64'h0);
      tick();
      check("flush_d_rvalid_t3", 64'(d_rvalid), 64'h1);
      check("flush_d_rdata_t3", d_rdata, 64'h1234);
      check("flush_if_rvalid_t3", 64'(if_rvalid), 64'h0);
      tick();

      // Store then load of the same word.
      d_req   = 1'b1;
      d_we    = 8'hFF;
      d_addr  = 32'h8;
      d_wdata = 64'hDEAD;
      tick();
      d_we = 8'h00;
      tick();
      idle();
      check("stld_mem_we_t2", 64'(mem_we), 64'h0);
      check("stld_d_rvalid_t2", 64'(d_rvalid), 64'h0);
      tick();
      check("stld_d_rvalid_t3", 64'(d_rvalid), 64'h1);
      check("stld_d_rdata_t3", d_rdata, 64'hDEAD);
      tick();

      // Reset one cycle after a load grant.
      d_req  = 1'b1;
      d_we   = 8'h00;
      d_addr = 32'h8;
      tick();
      idle();
      rstn = 1'b0;
      #1;
      check("midrst_mem_addr", 64'(mem_addr), 64'h0);
      check("midrst_mem_wdata", mem_wdata, 64'h0);
      check("midrst_mem_we", 64'(mem_we), 64'h0);
      if_req = 1'b1;
      d_req  = 1'b1;
      #1;
      check("midrst_gnts", 64'({if_gnt, d_gnt}), 64'h0);
      check("midrst_rvalid", 64'({if_rvalid, d_rvalid}), 64'h0);
      idle();
      tick();
      rstn = 1'b1;
      for (int c = 0; c < 3; c++) begin
         check($sformatf("postrst_rvalid%0d", c), 64'({if_rvalid, d_rvalid}), 64'h0);
         tick();
      end
      if_req = 1'b1;
      d_req  = 1'b1;
      #1;
      check("postrst_d_pri", 64'({if_gnt, d_gnt}), 64'h1);
      tick();
      idle();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single memory port between the instruction-fetch requester and the load/store requester of the execute phase. Each cycle it grants at most one request, drives the registered memory command, and tracks in-flight reads through a tag pipeline. Returning read data is steered back to the requester that issued the read. It sits between the core's fetch/execute phases and the memory, and includes starvation protection for fetch and flush-kill of stale fetch responses.

## Interface
Parameters:
- LOAD_LATENCY, 1, cycles from the memory command appearing on mem_* to mem_rdata being valid; must be ≥1
- STARVE_MAX, 4, consecutive lost arbitration cycles after which fetch is forced to win

Ports:
- clk  in  1  clock; all state is updated on the rising edge
- rstn  in  1  reset; asynchronous, active-low
- flush  in  1  pipeline flush: kills all in-flight fetch responses and any fetch grant in the same cycle
- if_req  in  1  fetch read request
- if_addr  in  `ADDR_W  fetch word address (64-bit word index)
- if_gnt  out  1  fetch request accepted this cycle (combinational)
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  `DATA_W  fetch read data
- d_req  in  1  data request
- d_addr  in  `ADDR_W  data word address
- d_we  in  8  byte write enables; 0 means load, non-zero means store
- d_wdata  in  `DATA_W  store data
- d_gnt  out  1  data request accepted this cycle (combinational)
- d_rvalid  out  1  load data valid
- d_rdata  out  `DATA_W  load data
- mem_addr  out  `ADDR_W  registered memory word address
- mem_we  out  8  registered byte enables
- mem_wdata  out  `DATA_W  registered store data
- mem_rdata  in  `DATA_W  memory read data

## Operation
- Arbitration FSM has two states: ARB_D_PRI (reset state) and ARB_IF_PRI.
- In ARB_D_PRI:
  - d_req wins if asserted; otherwise if_req wins.
  - starve_cnt increments in each cycle where if_req and d_req are both high and data wins.
  - When starve_cnt reaches STARVE_MAX, the FSM moves to ARB_IF_PRI.
- In ARB_IF_PRI:
  - if_req wins if asserted (and flush is low); otherwise d_req wins.
  - The FSM returns to ARB_D_PRI after the first fetch grant.
- starve_cnt clears on any fetch grant or any cycle with if_req low. Width is $clog2(STARVE_MAX+1).
- flush forces if_gnt=0. d_req can then win in the same cycle.
- At most one gnt is high in any cycle. A gnt is never high without its req.
- Granted request is latched into mem_addr/mem_we/mem_wdata on the next edge. Fetch grants always set mem_we=0.
- Cycles with no grant set mem_we=0. mem_addr and mem_wdata hold their previous values.
- Tag pipeline has depth LOAD_LATENCY+1. Each entry is {valid, owner ∈ {IF, D}}.
  - Load and fetch grants push valid=1. Store and idle cycles push valid=0.
  - The tag shifts every cycle.
- Tag output routing:
  - if_rvalid = tag.valid && owner==IF
  - d_rvalid = tag.valid && owner==D
  - Each rdata output equals mem_rdata while its rvalid is high, else 0.
- flush clears valid on every in-flight IF tag. D tags are unaffected.
- Stores never produce an rvalid.

## Timing
- Grant in cycle t → mem_* valid in cycle t+1 → rvalid/rdata in cycle t+1+LOAD_LATENCY. With the default, load-to-use is 2 cycles.
- Throughput: one request per cycle total. Back-to-back grants to either requester are legal.
- A store at t followed by a read of the same word at t+1 returns the stored data; the memory is write-first.
- flush in cycle t suppresses all IF rvalids in t+1 onward for requests granted at or before t. Fetch grants from t+1 on return normally.
- Reset asserted (asynchronously), including mid-operation:
  - mem_addr=0, mem_we=0, mem_wdata=0
  - all tags invalid, so if_rvalid=d_rvalid=0
  - if_gnt=d_gnt=0 while rstn is low
  - FSM=ARB_D_PRI, starve_cnt=0
- In-flight responses at reset are lost; no rvalid is produced after release.

## Structure
- Shared package:
  - owner_t enum {OWN_IF, OWN_D}
  - mem_tag_t struct {valid, owner}
  - arb_state_t enum {ARB_D_PRI, ARB_IF_PRI}
  - `ADDR_W and `DATA_W come from common_params.h.
- Sub-module mem_tag_pipe:
  - parameterised shift register of mem_tag_t, depth LOAD_LATENCY+1
  - inputs: push tag, kill_if
  - output: tag at its head
- The top level holds the FSM, starve counter, grant logic and command registers.

## Test plan
- Fetch only:
  - Stimulus: if_req=1, if_addr=0x10; memory returns 0xAAAA_0000_0000_0010.
  - Response: if_gnt=1 at t, mem_addr=0x10 and mem_we=0 at t+1, if_rvalid with that data at t+2.
- Collision:
  - Stimulus: if_req=d_req=1, d_we=0xFF, d_addr=0x20, d_wdata=0x1234.
  - Response: d_gnt=1, if_gnt=0; mem_we=0xFF, mem_wdata=0x1234 next cycle; no rvalid.
- Starvation:
  - Stimulus: if_req and d_req held high for 6 cycles, STARVE_MAX=4.
  - Response: d_gnt for cycles 0–3, if_gnt in cycle 4, d_gnt in cycle 5.
- Flush kill:
  - Stimulus: fetch granted at t, flush at t+1.
  - Response: no if_rvalid at t+2; a data load granted at t+1 still gives d_rvalid at t+3.
- Store-then-load:
  - Stimulus: store 0xDEAD to 0x8 at t, load 0x8 at t+1.
  - Response: d_rvalid at t+3 with d_rdata=0xDEAD; mem_we is 0 at t+2.
- Reset mid-flight:
  - Stimulus: rstn low one cycle after a load grant.
  - Response: all outputs 0 immediately; no rvalid after release; FSM restarts in ARB_D_PRI.
